// File: rtl/wb_regfile_pkg.sv
// Shared pipeline definitions: result-select encoding and register index width.
package wb_regfile_pkg;

   localparam int REG_IDX_W = 5;

   typedef enum logic [1:0] {
      RESULT_ALU   = 2'b00,
      RESULT_MEM   = 2'b01,
      RESULT_PC4   = 2'b10,
      RESULT_PCTGT = 2'b11
   } result_src_e;

   // A W-stage write is architecturally visible only when enabled and not aimed at x0.
   function automatic logic is_commit(input logic we, input logic [REG_IDX_W-1:0] rd);
      return we && (rd != {REG_IDX_W{1'b0}});
   endfunction

endpackage

// File: rtl/wb_regfile_result_mux.sv
// 4:1 result selector keyed by the shared result-source enum.
module result_mux
   import wb_regfile_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  result_src_e      sel_i,
   input  logic [XLEN-1:0]  alu_i,
   input  logic [XLEN-1:0]  mem_i,
   input  logic [XLEN-1:0]  pc4_i,
   input  logic [XLEN-1:0]  pctgt_i,
   output logic [XLEN-1:0]  result_o
);

   // Pick one candidate result; every encoding is defined.
   always_comb begin
      result_o = alu_i;
      case (sel_i)
         RESULT_ALU:   result_o = alu_i;
         RESULT_MEM:   result_o = mem_i;
         RESULT_PC4:   result_o = pc4_i;
         RESULT_PCTGT: result_o = pctgt_i;
         default:      result_o = alu_i;
      endcase
   end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: result select, 32x32 integer register file with x0 fixed to
// zero, two bypassing decode read ports and a saturating committed-write counter.
module wb_regfile
   import wb_regfile_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int CNTW = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  RegWriteW,
   input  logic [1:0]            ResultSrcW,
   input  logic [XLEN-1:0]       ALUResultW,
   input  logic [XLEN-1:0]       ReadDataW,
   input  logic [XLEN-1:0]       PCPlus4W,
   input  logic [XLEN-1:0]       PCTargetW,
   input  logic [REG_IDX_W-1:0]  RdW,
   input  logic [REG_IDX_W-1:0]  Rs1D,
   input  logic [REG_IDX_W-1:0]  Rs2D,
   output logic [XLEN-1:0]       RD1D,
   output logic [XLEN-1:0]       RD2D,
   output logic [XLEN-1:0]       ResultW,
   output logic [CNTW-1:0]       WriteCount
);

   logic [XLEN-1:0] rf_q [1:NREG-1];
   logic [CNTW-1:0] cnt_q;
   logic [CNTW-1:0] cnt_d;
   logic            commit_s;
   logic [XLEN-1:0] rd1_stored_s;
   logic [XLEN-1:0] rd2_stored_s;

   result_mux #(.XLEN(XLEN)) u_result_mux (
      .sel_i    (result_src_e'(ResultSrcW)),
      .alu_i    (ALUResultW),
      .mem_i    (ReadDataW),
      .pc4_i    (PCPlus4W),
      .pctgt_i  (PCTargetW),
      .result_o (ResultW)
   );

   assign commit_s = is_commit(RegWriteW, RdW);

   // Register array x1..x31; x0 has no storage so it can never hold a value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 1; i < NREG; i++) begin
            rf_q[i] <= {XLEN{1'b0}};
         end
      end else begin
         for (int i = 1; i < NREG; i++) begin
            if (commit_s && (RdW == REG_IDX_W'(i))) begin
               rf_q[i] <= ResultW;
            end
         end
      end
   end

   // Next committed-write count; holds at all-ones instead of wrapping.
   always_comb begin
      if (commit_s && (cnt_q != {CNTW{1'b1}})) begin
         cnt_d = cnt_q + CNTW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Committed-write counter register, updated on the same edge as the array.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= {CNTW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign WriteCount = cnt_q;

   // Stored-value lookup for both read ports (index 0 falls through to zero).
   always_comb begin
      rd1_stored_s = {XLEN{1'b0}};
      rd2_stored_s = {XLEN{1'b0}};
      for (int i = 1; i < NREG; i++) begin
         if (Rs1D == REG_IDX_W'(i)) begin
            rd1_stored_s = rf_q[i];
         end
         if (Rs2D == REG_IDX_W'(i)) begin
            rd2_stored_s = rf_q[i];
         end
      end
   end

   // Read ports: x0 is zero, a same-cycle commit to the source is bypassed,
   // otherwise the stored value is returned.
   always_comb begin
      if (Rs1D == {REG_IDX_W{1'b0}}) begin
         RD1D = {XLEN{1'b0}};
      end else if (commit_s && (RdW == Rs1D)) begin
         RD1D = ResultW;
      end else begin
         RD1D = rd1_stored_s;
      end

      if (Rs2D == {REG_IDX_W{1'b0}}) begin
         RD2D = {XLEN{1'b0}};
      end else if (commit_s && (RdW == Rs2D)) begin
         RD2D = ResultW;
      end else begin
         RD2D = rd2_stored_s;
      end
   end

endmodule
